// File: rtl/pkt_tx_gen.sv
// pkt_tx_gen: packet source for the xge_mac pkt_tx interface.
// Produces runs of packets whose byte k in packet p is (p + k) mod 256.
// The packet length, the packet count and the inter-packet gap are
// captured on start. The source stalls while pkt_tx_full is high.
//
// Ports
//   clk_156m25, reset_156m25  core clock, async active-high reset
//   start, stop               run control pulses
//   cfg_len/count/gap         run configuration, latched on start
//   pkt_tx_full               backpressure from the MAC transmit FIFO
//   pkt_tx_*                  registered packet word interface
//   busy, done, tx_pkt_cnt    run status
//
// state | meaning
// IDLE  | no run; also spends one cycle here flagging done after the last eop
// SEND  | a word of the current packet is pending
// GAP   | idle cycles between eop and the next sop
module pkt_tx_gen #(
   parameter int LEN_W = 14,
   parameter int CNT_W = 16
) (
   input  logic             clk_156m25,
   input  logic             reset_156m25,
   input  logic             start,
   input  logic             stop,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic [7:0]       cfg_gap,
   input  logic             pkt_tx_full,
   output logic [63:0]      pkt_tx_data,
   output logic             pkt_tx_val,
   output logic             pkt_tx_sop,
   output logic             pkt_tx_eop,
   output logic [2:0]       pkt_tx_mod,
   output logic             busy,
   output logic             done,
   output logic [31:0]      tx_pkt_cnt
);

   localparam int WRD_W = LEN_W - 2;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t           r_state, w_state;
   logic [LEN_W-1:0] r_len, w_len;
   logic [WRD_W-1:0] r_words, w_words, r_word, w_word;
   logic [7:0]       r_pidx, w_pidx, r_gap, w_gap, r_gap_cnt, w_gap_cnt;
   logic [CNT_W-1:0] r_left, w_left;
   logic             r_cnt_en, w_cnt_en, r_stop_pend, w_stop_pend, r_ending, w_ending;
   logic [63:0]      r_data, w_data;
   logic             r_val, w_val, r_sop, w_sop, r_eop, w_eop;
   logic [2:0]       r_mod, w_mod;
   logic             r_busy, w_busy, r_done, w_done;
   logic [31:0]      r_pkt_cnt, w_pkt_cnt;
   logic             w_send, w_last;
   logic [LEN_W-1:0] w_len_eff;
   logic [3:0]       w_nbytes;
   logic [7:0]       w_base;

   assign w_len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

   always_comb begin
      w_state     = r_state;
      w_len       = r_len;
      w_words     = r_words;
      w_word      = r_word;
      w_pidx      = r_pidx;
      w_gap       = r_gap;
      w_gap_cnt   = r_gap_cnt;
      w_left      = r_left;
      w_cnt_en    = r_cnt_en;
      w_stop_pend = r_stop_pend;
      w_ending    = r_ending;
      w_data      = r_data;
      w_val       = 1'b0;
      w_sop       = 1'b0;
      w_eop       = 1'b0;
      w_mod       = 3'd0;
      w_busy      = r_busy;
      w_done      = 1'b0;
      w_pkt_cnt   = r_pkt_cnt;
      w_send      = 1'b0;
      w_last      = 1'b0;
      w_nbytes    = 4'd0;
      w_base      = 8'd0;

      case (r_state)
         S_IDLE: begin
            // r_ending keeps busy high for the done cycle, so start is ignored then
            if (r_ending) begin
               w_ending = 1'b0;
               w_busy   = 1'b0;
               w_done   = 1'b1;
            end else if (start) begin
               w_len       = w_len_eff;
               w_words     = {1'b0, w_len_eff[LEN_W-1:3]} + WRD_W'(|w_len_eff[2:0]);
               w_gap       = cfg_gap;
               w_left      = cfg_count;
               w_cnt_en    = |cfg_count;
               w_pidx      = 8'd0;
               w_word      = '0;
               w_pkt_cnt   = 32'd0;
               w_stop_pend = 1'b0;
               w_busy      = 1'b1;
               w_state     = S_SEND;
               w_send      = 1'b1;
            end
         end
         S_SEND: begin
            w_send = 1'b1;
            if (stop) w_stop_pend = 1'b1;
         end
         S_GAP: begin
            if (stop) begin
               w_state     = S_IDLE;
               w_busy      = 1'b0;
               w_done      = 1'b1;
               w_stop_pend = 1'b0;
            end else if (r_gap_cnt <= 8'd1) begin
               w_state = S_SEND;
            end else begin
               w_gap_cnt = r_gap_cnt - 8'd1;
            end
         end
         default: w_state = S_IDLE;
      endcase

      // word emission uses the freshly latched config on the start cycle
      if (w_send && !pkt_tx_full) begin
         w_last   = (w_word == w_words - WRD_W'(1));
         w_nbytes = (w_last && w_len[2:0] != 3'd0) ? {1'b0, w_len[2:0]} : 4'd8;
         w_base   = w_pidx + 8'({w_word, 3'b000});
         for (int j = 0; j < 8; j++) begin
            w_data[63-8*j -: 8] = (4'(j) < w_nbytes) ? w_base + 8'(j) : 8'h00;
         end
         w_val = 1'b1;
         w_sop = (w_word == '0);
         if (w_last) begin
            w_eop     = 1'b1;
            w_mod     = w_len[2:0];
            w_pkt_cnt = w_pkt_cnt + 32'd1;
            w_pidx    = w_pidx + 8'd1;
            w_word    = '0;
            if (w_cnt_en) w_left = w_left - CNT_W'(1);
            if ((w_cnt_en && w_left == '0) || w_stop_pend) begin
               w_state     = S_IDLE;
               w_ending    = 1'b1;
               w_stop_pend = 1'b0;
            end else if (w_gap != 8'd0) begin
               w_state   = S_GAP;
               w_gap_cnt = w_gap;
            end else begin
               w_state = S_SEND;
            end
         end else begin
            w_word = w_word + WRD_W'(1);
         end
      end
   end

   always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
      if (reset_156m25) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_words     <= '0;
         r_word      <= '0;
         r_pidx      <= 8'd0;
         r_gap       <= 8'd0;
         r_gap_cnt   <= 8'd0;
         r_left      <= '0;
         r_cnt_en    <= 1'b0;
         r_stop_pend <= 1'b0;
         r_ending    <= 1'b0;
         r_data      <= 64'd0;
         r_val       <= 1'b0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_mod       <= 3'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pkt_cnt   <= 32'd0;
      end else begin
         r_state     <= w_state;
         r_len       <= w_len;
         r_words     <= w_words;
         r_word      <= w_word;
         r_pidx      <= w_pidx;
         r_gap       <= w_gap;
         r_gap_cnt   <= w_gap_cnt;
         r_left      <= w_left;
         r_cnt_en    <= w_cnt_en;
         r_stop_pend <= w_stop_pend;
         r_ending    <= w_ending;
         r_data      <= w_data;
         r_val       <= w_val;
         r_sop       <= w_sop;
         r_eop       <= w_eop;
         r_mod       <= w_mod;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_pkt_cnt   <= w_pkt_cnt;
      end
   end

   assign pkt_tx_data = r_data;
   assign pkt_tx_val  = r_val;
   assign pkt_tx_sop  = r_sop;
   assign pkt_tx_eop  = r_eop;
   assign pkt_tx_mod  = r_mod;
   assign busy        = r_busy;
   assign done        = r_done;
   assign tx_pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_pkt_tx_gen.sv
// Testbench for pkt_tx_gen: table of runs, directed corner sequences and
// randomized runs, all checked against a byte-pattern model of the stream.
module tb_pkt_tx_gen;

   logic        clk_156m25 = 1'b0;
   logic        reset_156m25 = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [13:0] cfg_len = '0;
   logic [15:0] cfg_count = '0;
   logic [7:0]  cfg_gap = '0;
   logic        pkt_tx_full = 1'b0;
   logic [63:0] pkt_tx_data;
   logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
   logic [2:0]  pkt_tx_mod;
   logic        busy, done;
   logic [31:0] tx_pkt_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   pkt_tx_gen dut (
      .clk_156m25   (clk_156m25),
      .reset_156m25 (reset_156m25),
      .start        (start),
      .stop         (stop),
      .cfg_len      (cfg_len),
      .cfg_count    (cfg_count),
      .cfg_gap      (cfg_gap),
      .pkt_tx_full  (pkt_tx_full),
      .pkt_tx_data  (pkt_tx_data),
      .pkt_tx_val   (pkt_tx_val),
      .pkt_tx_sop   (pkt_tx_sop),
      .pkt_tx_eop   (pkt_tx_eop),
      .pkt_tx_mod   (pkt_tx_mod),
      .busy         (busy),
      .done         (done),
      .tx_pkt_cnt   (tx_pkt_cnt)
   );

   always #5 clk_156m25 = ~clk_156m25;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // reference: byte k of packet p is (p+k) mod 256, bytes past len are 0
   function automatic logic [63:0] exp_word(input int p, input int w, input int len);
      logic [63:0] r;
      int k;
      r = '0;
      for (int j = 0; j < 8; j++) begin
         k = w * 8 + j;
         if (k < len) r[63-8*j -: 8] = 8'((p + k) % 256);
      end
      return r;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, " data"}, pkt_tx_data, 0);
      chk({tag, " val"}, 64'(pkt_tx_val), 0);
      chk({tag, " sop"}, 64'(pkt_tx_sop), 0);
      chk({tag, " eop"}, 64'(pkt_tx_eop), 0);
      chk({tag, " mod"}, 64'(pkt_tx_mod), 0);
      chk({tag, " busy"}, 64'(busy), 0);
      chk({tag, " done"}, 64'(done), 0);
      chk({tag, " cnt"}, 64'(tx_pkt_cnt), 0);
   endtask

   // One run: start, watch every cycle, compare each word to the model.
   task automatic run_pkt(input int len, input int cnt, input int gap, input int pfull,
                          input int stop_pkt, input int bp_word, input string tag,
                          output logic [63:0] first, output logic [63:0] last,
                          output int o_mod, output int nwords, output int mid_idle);
      int leff, wpp, npk, pi, wi, cyc, last_eop, idle, bp_left;
      bit prev_full, waiting, gap_full, stop_sent, finished;
      leff = (len == 0) ? 1 : len;
      wpp  = (leff + 7) / 8;
      npk  = (stop_pkt >= 0 && (cnt == 0 || stop_pkt < cnt)) ? stop_pkt + 1 : cnt;
      pi = 0; wi = 0; cyc = 0; last_eop = -100; idle = 0; bp_left = 0;
      prev_full = 0; waiting = 0; gap_full = 0; stop_sent = 0; finished = 0;
      first = '0; last = '0; o_mod = 0; nwords = 0; mid_idle = 0;
      @(negedge clk_156m25);
      cfg_len = 14'(len); cfg_count = 16'(cnt); cfg_gap = 8'(gap);
      pkt_tx_full = 1'b0; start = 1'b1;
      while (!finished && cyc < 20000) begin
         @(negedge clk_156m25);
         cyc++;
         start = 1'b0; stop = 1'b0;
         if (cyc == 1) begin
            chk({tag, " start latency val"}, 64'(pkt_tx_val), 1);
            chk({tag, " start latency sop"}, 64'(pkt_tx_sop), 1);
            chk({tag, " busy"}, 64'(busy), 1);
         end
         if (prev_full) chk({tag, " val after full"}, 64'(pkt_tx_val), 0);
         if (pkt_tx_val) begin
            chk({tag, " extra word"}, 64'(pi < npk), 1);
            chk({tag, " data"}, pkt_tx_data, exp_word(pi, wi, leff));
            chk({tag, " sop"}, 64'(pkt_tx_sop), 64'(wi == 0));
            chk({tag, " eop"}, 64'(pkt_tx_eop), 64'(wi == wpp - 1));
            chk({tag, " mod"}, 64'(pkt_tx_mod), (wi == wpp - 1) ? 64'(leff % 8) : 64'd0);
            if (waiting && wi == 0) begin
               if (!gap_full) chk({tag, " gap"}, 64'(idle), 64'(gap));
               else chk({tag, " gap min"}, 64'(idle >= gap), 1);
               waiting = 0;
            end
            if (nwords == 0) first = pkt_tx_data;
            nwords++;
            if (wi == 0 && pi == stop_pkt && wpp > 1 && !stop_sent) begin
               stop = 1'b1; stop_sent = 1;
            end
            if (bp_word == nwords - 1) bp_left = 5;
            if (wi == wpp - 1) begin
               last = pkt_tx_data; o_mod = int'(pkt_tx_mod); last_eop = cyc;
               pi++; wi = 0; waiting = 1; idle = 0; gap_full = 0;
            end else begin
               wi++;
            end
         end else if (waiting) begin
            idle++;
            if (prev_full) gap_full = 1;
         end else if (wi > 0) begin
            mid_idle++;
            if (!prev_full) chk({tag, " stall without full"}, 64'(pkt_tx_val), 1);
         end
         if (done) begin
            chk({tag, " done timing"}, 64'(cyc), 64'(last_eop + 1));
            chk({tag, " busy at done"}, 64'(busy), 0);
            chk({tag, " tx_pkt_cnt"}, 64'(tx_pkt_cnt), 64'(npk));
            chk({tag, " packets"}, 64'(pi), 64'(npk));
            finished = 1;
         end
         if (cyc == 1) begin
            start = 1'b1;                   // ignored: run already busy
            cfg_len = 14'(len + 3);
         end
         if (bp_left > 0) begin
            pkt_tx_full = 1'b1; bp_left--;
         end else begin
            pkt_tx_full = ($urandom_range(0, 99) < pfull);
         end
         prev_full = pkt_tx_full;
      end
      if (!finished) begin
         n_cmp++; n_bad++;
         $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
      end
      pkt_tx_full = 1'b0; start = 1'b0; stop = 1'b0;
      repeat (3) begin
         @(negedge clk_156m25);
         chk({tag, " done after end"}, 64'(done), 0);
         chk({tag, " val after end"}, 64'(pkt_tx_val), 0);
      end
   endtask

   typedef struct {
      int          len;
      int          cnt;
      int          gap;
      int          words;
      logic [63:0] first;
      logic [63:0] last;
      int          mod;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [63:0] f, l;
      int m, nw, mi, len, cnt, gap, sp;

      vecs[0] = '{64, 1, 0, 8, 64'h0001020304050607, 64'h38393A3B3C3D3E3F, 0};
      vecs[1] = '{61, 1, 0, 8, 64'h0001020304050607, 64'h38393A3B3C000000, 5};
      vecs[2] = '{16, 3, 4, 6, 64'h0001020304050607, 64'h0A0B0C0D0E0F1011, 0};
      vecs[3] = '{0,  2, 1, 2, 64'h0000000000000000, 64'h0100000000000000, 1};
      vecs[4] = '{9,  1, 0, 2, 64'h0001020304050607, 64'h0800000000000000, 1};
      vecs[5] = '{8,  2, 0, 2, 64'h0001020304050607, 64'h0102030405060708, 0};

      #1;
      chk_all_zero("reset async");
      @(negedge clk_156m25);
      chk_all_zero("reset");
      reset_156m25 = 1'b0;
      repeat (2) @(negedge clk_156m25);
      chk_all_zero("after reset");

      for (int i = 0; i < 6; i++) begin
         run_pkt(vecs[i].len, vecs[i].cnt, vecs[i].gap, 0, -1, -1, $sformatf("vec%0d", i), f, l, m, nw, mi);
         chk($sformatf("vec%0d first", i), f, vecs[i].first);
         chk($sformatf("vec%0d last", i), l, vecs[i].last);
         chk($sformatf("vec%0d last mod", i), 64'(m), 64'(vecs[i].mod));
         chk($sformatf("vec%0d words", i), 64'(nw), 64'(vecs[i].words));
      end

      // backpressure: full held 5 cycles after word 3
      run_pkt(64, 1, 0, 0, -1, 3, "bp", f, l, m, nw, mi);
      chk("bp stall cycles", 64'(mi), 5);
      chk("bp words", 64'(nw), 8);

      // continuous run, stop during packet 4
      run_pkt(24, 0, 2, 0, 4, -1, "stop", f, l, m, nw, mi);
      chk("stop words", 64'(nw), 15);

      // stop arriving during the gap ends the run the next cycle
      @(negedge clk_156m25);
      cfg_len = 14'd8; cfg_count = 16'd0; cfg_gap = 8'd4; start = 1'b1;
      @(negedge clk_156m25);
      start = 1'b0;
      chk("gapstop eop", 64'(pkt_tx_eop), 1);
      stop = 1'b1;
      @(negedge clk_156m25);
      stop = 1'b0;
      chk("gapstop done", 64'(done), 1);
      chk("gapstop busy", 64'(busy), 0);
      chk("gapstop cnt", 64'(tx_pkt_cnt), 1);
      chk("gapstop val", 64'(pkt_tx_val), 0);
      @(negedge clk_156m25);
      chk("gapstop single done", 64'(done), 0);

      // reset in the middle of a packet
      @(negedge clk_156m25);
      cfg_len = 14'd64; cfg_count = 16'd1; cfg_gap = 8'd0; start = 1'b1;
      @(negedge clk_156m25);
      start = 1'b0;
      repeat (2) @(negedge clk_156m25);
      chk("rst word2", pkt_tx_data, exp_word(0, 2, 64));
      #1 reset_156m25 = 1'b1;
      #1 chk_all_zero("mid reset");
      @(negedge clk_156m25);
      reset_156m25 = 1'b0;
      @(negedge clk_156m25);
      chk_all_zero("post reset");
      run_pkt(64, 1, 0, 0, -1, -1, "rerun", f, l, m, nw, mi);
      chk("rerun first", f, 64'h0001020304050607);

      // randomized runs with random backpressure
      for (int r = 0; r < 8; r++) begin
         len = (r == 0) ? 0 : int'($urandom_range(1, 90));
         cnt = int'($urandom_range(1, 4));
         gap = int'($urandom_range(0, 3));
         sp  = (len >= 9 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, cnt - 1)) : -1;
         run_pkt(len, cnt, gap, 30, sp, -1, $sformatf("rand%0d", r), f, l, m, nw, mi);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
